// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the icache refill path
// and the dcache refill/writeback path. Round-robin grant, one transaction
// in flight, write beats streamed straight through, response beats routed
// by the top bit of the memory tag (0 = icache, 1 = dcache).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate and handshake with a client
// REQ   | present latched request on mem_req_*, wait for mem_req_ready
// WDATA | pass dcache write beats through, count WRITE_BEATS handshakes
// RESP  | count READ_BEATS response beats tagged for the granted client
module mem_arbiter #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int TAG_W       = 5,
  parameter int WRITE_BEATS = 4,
  parameter int READ_BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic [TAG_W-2:0]    ic_req_tag,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  output logic [TAG_W-2:0]    ic_resp_tag,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [TAG_W-2:0]    dc_req_tag,
  input  logic                dc_req_data_valid,
  output logic                dc_req_data_ready,
  input  logic [DATA_W-1:0]   dc_req_data_bits,
  input  logic [DATA_W/8-1:0] dc_req_data_mask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic [TAG_W-2:0]    dc_resp_tag,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  input  logic [TAG_W-1:0]    mem_resp_tag
);

  localparam int MAX_BEATS = (WRITE_BEATS > READ_BEATS) ? WRITE_BEATS : READ_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BEATS - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              last_grant, last_grant_nxt;   // 1 = dcache was granted last
  logic              lat_rw, lat_rw_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [TAG_W-1:0]  lat_tag, lat_tag_nxt;
  logic              grant_dc, grant_ic, beat;

  // state and latched request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= 1'b0;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_tag    <= '0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_grant <= last_grant_nxt;
      lat_rw     <= lat_rw_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_tag    <= lat_tag_nxt;
    end
  end

  // next-state, arbitration and handshake outputs
  always_comb begin
    state_nxt          = state;
    beat_cnt_nxt       = beat_cnt;
    last_grant_nxt     = last_grant;
    lat_rw_nxt         = lat_rw;
    lat_addr_nxt       = lat_addr;
    lat_tag_nxt        = lat_tag;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    dc_req_data_ready  = 1'b0;
    beat               = 1'b0;
    // on a tie the client that did not win last time gets the grant
    grant_dc           = dc_req_valid & (~ic_req_valid | ~last_grant);
    grant_ic           = ic_req_valid & ~grant_dc;
    case (state)
      IDLE: begin
        // reset holds state in IDLE, so gating here keeps readys low in reset
        ic_req_ready = grant_ic & reset;
        dc_req_ready = grant_dc & reset;
        if (grant_ic | grant_dc) begin
          state_nxt      = REQ;
          last_grant_nxt = grant_dc;
          lat_rw_nxt     = grant_dc & dc_req_rw;
          lat_addr_nxt   = grant_dc ? dc_req_addr : ic_req_addr;
          lat_tag_nxt    = grant_dc ? {1'b1, dc_req_tag} : {1'b0, ic_req_tag};
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = lat_rw ? WDATA : RESP;
      end
      WDATA: begin
        mem_req_data_valid = dc_req_data_valid;
        dc_req_data_ready  = mem_req_data_ready;
        beat               = dc_req_data_valid & mem_req_data_ready;
        if (beat) begin
          if (beat_cnt == WR_LAST) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      RESP: begin
        beat = mem_resp_valid & (mem_resp_tag[TAG_W-1] == lat_tag[TAG_W-1]);
        if (beat) begin
          if (beat_cnt == RD_LAST) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req_rw        = lat_rw;
  assign mem_req_addr      = lat_addr;
  assign mem_req_tag       = lat_tag;
  assign mem_req_data_bits = dc_req_data_bits;
  assign mem_req_data_mask = dc_req_data_mask;

  // responses are routed in every state; beats outside RESP are not counted
  assign ic_resp_valid = reset & mem_resp_valid & ~mem_resp_tag[TAG_W-1];
  assign dc_resp_valid = reset & mem_resp_valid &  mem_resp_tag[TAG_W-1];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;
  assign ic_resp_tag   = mem_resp_tag[TAG_W-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_W-2:0];

endmodule
